hdlc_deframer: RTL and testbench

HDLC_DEFRAMER -- requirements
Module: hdlc_deframer

---
 rtl/hdlc_deframer.sv | 190 +++++++++++++++++++
 tb/tb_hdlc_deframer.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_deframer.sv
// HDLC receive deframer: finds flags on a serial line, removes stuffed zeros,
// packs bits LSB-first into W-bit words and marks the first and last word of
// each frame. Aborts and frames that close on a partial word are reported on err.
//
// state | meaning
// ------+-----------------------------------------------------------------
// HUNT  | not aligned; waiting for a flag, everything else is ignored
// SYNC  | flag seen; collecting bits, no complete word held yet
// DATA  | at least one complete word held in pending, awaiting next word or flag
module hdlc_deframer #(
    parameter int W = 8,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         in,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         sof,
    output logic         eof,
    output logic         flag,
    output logic         disc,
    output logic         err
);

    // ones_cnt must reach N+2; bit_cnt only ever reaches W-1 before wrapping.
    localparam int OW = $clog2(N + 3);
    localparam int BW = $clog2(W + 1);

    localparam logic [OW-1:0] ONES_STUFF = OW'(N);
    localparam logic [OW-1:0] ONES_FLAG  = OW'(N + 1);
    localparam logic [OW-1:0] ONES_MAX   = OW'(N + 2);
    localparam logic [BW-1:0] BITS_LAST  = BW'(W - 1);
    localparam logic [BW-1:0] BITS_TAIL  = BW'(N + 2);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BIT_DATA  = 2'd0,
        BIT_STUFF = 2'd1,
        BIT_FLAG  = 2'd2,
        BIT_ABORT = 2'd3
    } bit_class_t;

    state_t          state;
    bit_class_t      bit_class;
    logic [OW-1:0]   ones_cnt;
    logic [OW-1:0]   ones_next;
    logic [BW-1:0]   bit_cnt;
    logic [W-1:0]    sh;
    logic [W-1:0]    sh_next;
    logic [W-1:0]    pending;
    logic            pending_valid;
    logic            first_word;

    // Classify the incoming bit from the run of ones seen before it.
    always_comb begin
        bit_class = BIT_DATA;
        if (!in && ones_cnt == ONES_FLAG) begin
            bit_class = BIT_FLAG;
        end else if (!in && ones_cnt == ONES_STUFF) begin
            bit_class = BIT_STUFF;
        end else if (in && ones_cnt == ONES_FLAG) begin
            bit_class = BIT_ABORT;
        end
    end

    // Next value of the ones run counter (saturating) and of the shift register.
    always_comb begin
        ones_next = '0;
        if (in) begin
            ones_next = (ones_cnt == ONES_MAX) ? ones_cnt : ones_cnt + 1'b1;
        end
        sh_next = {in, sh[W-1:1]};
    end

    // Deframing state machine with registered outputs; pulses default low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HUNT;
            ones_cnt      <= '0;
            bit_cnt       <= '0;
            sh            <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            first_word    <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            sof           <= 1'b0;
            eof           <= 1'b0;
            flag          <= 1'b0;
            disc          <= 1'b0;
            err           <= 1'b0;
        end else begin
            out_data  <= '0;
            out_valid <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            flag      <= 1'b0;
            disc      <= 1'b0;
            err       <= 1'b0;

            if (in_valid) begin
                ones_cnt <= ones_next;

                case (state)
                    HUNT: begin
                        if (bit_class == BIT_FLAG) begin
                            flag          <= 1'b1;
                            state         <= SYNC;
                            bit_cnt       <= '0;
                            pending_valid <= 1'b0;
                            first_word    <= 1'b1;
                        end
                    end

                    SYNC, DATA: begin
                        case (bit_class)
                            BIT_DATA: begin
                                sh <= sh_next;
                                if (bit_cnt == BITS_LAST) begin
                                    // A new word is complete: release the one held
                                    // before it, then hold the new one until we know
                                    // whether it is the frame's last.
                                    if (pending_valid) begin
                                        out_valid  <= 1'b1;
                                        out_data   <= pending;
                                        sof        <= first_word;
                                        first_word <= 1'b0;
                                    end
                                    pending       <= sh_next;
                                    pending_valid <= 1'b1;
                                    bit_cnt       <= '0;
                                    state         <= DATA;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end

                            BIT_STUFF: begin
                                disc <= 1'b1;
                            end

                            BIT_FLAG: begin
                                flag <= 1'b1;
                                // A clean frame ends with exactly the flag's own
                                // leading 0 and N+1 ones sitting in the partial word.
                                if (pending_valid) begin
                                    if (bit_cnt == BITS_TAIL) begin
                                        out_valid <= 1'b1;
                                        out_data  <= pending;
                                        sof       <= first_word;
                                        eof       <= 1'b1;
                                    end else begin
                                        err <= 1'b1;
                                    end
                                end
                                state         <= SYNC;
                                bit_cnt       <= '0;
                                pending_valid <= 1'b0;
                                first_word    <= 1'b1;
                            end

                            BIT_ABORT: begin
                                err           <= 1'b1;
                                state         <= HUNT;
                                bit_cnt       <= '0;
                                pending_valid <= 1'b0;
                            end

                            default: begin
                                state <= HUNT;
                            end
                        endcase
                    end

                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdlc_deframer.sv
// Self-checking bench for hdlc_deframer (N=5, W=8). A frame-level reference
// model predicts every cycle's outputs; each test compares the recorded
// cycles against it and also checks the headline behaviour with constants.
module tb_hdlc_deframer;

    localparam int W    = 8;
    localparam int N    = 5;
    localparam int EW   = W + 6;
    localparam int MAXC = 40000;

    localparam int P_ERR  = W;
    localparam int P_DISC = W + 1;
    localparam int P_FLAG = W + 2;
    localparam int P_EOF  = W + 3;
    localparam int P_SOF  = W + 4;
    localparam int P_VAL  = W + 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid, sof, eof, flag, disc, err;

    always #5 clk = ~clk;

    hdlc_deframer #(.W(W), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .sof       (sof),
        .eof       (eof),
        .flag      (flag),
        .disc      (disc),
        .err       (err)
    );

    logic [EW-1:0] obs_ev [MAXC];
    logic [EW-1:0] exp_ev [MAXC];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int gap_mode = 0;
    int enc_ones = 0;

    // reference model state: frame-level view of the receiver
    int            m_ones;
    bit            m_hunt;
    bit            m_bits[$];
    logic [W-1:0]  m_pend;
    bit            m_pv;
    bit            m_first;

    task automatic model_reset();
        m_ones  = 0;
        m_hunt  = 1;
        m_bits.delete();
        m_pend  = '0;
        m_pv    = 0;
        m_first = 0;
    endtask

    task automatic model_bit(input logic b, output logic [EW-1:0] ev);
        int run;
        logic [W-1:0] word;
        run = m_ones;
        m_ones = b ? ((m_ones == N + 2) ? N + 2 : m_ones + 1) : 0;
        ev = '0;
        if (m_hunt) begin
            if (!b && run == N + 1) begin
                ev[P_FLAG] = 1'b1;
                m_hunt = 0;
                m_bits.delete();
                m_pv = 0;
                m_first = 1;
            end
        end else if (!b && run == N + 1) begin
            ev[P_FLAG] = 1'b1;
            if (m_pv) begin
                if (m_bits.size() == N + 2) begin
                    ev[P_VAL] = 1'b1;
                    ev[P_EOF] = 1'b1;
                    ev[P_SOF] = m_first;
                    ev[W-1:0] = m_pend;
                end else begin
                    ev[P_ERR] = 1'b1;
                end
            end
            m_bits.delete();
            m_pv = 0;
            m_first = 1;
        end else if (!b && run == N) begin
            ev[P_DISC] = 1'b1;
        end else if (b && run == N + 1) begin
            ev[P_ERR] = 1'b1;
            m_hunt = 1;
            m_bits.delete();
            m_pv = 0;
        end else begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) word[i] = m_bits[i];
                if (m_pv) begin
                    ev[P_VAL] = 1'b1;
                    ev[P_SOF] = m_first;
                    ev[W-1:0] = m_pend;
                    m_first = 0;
                end
                m_pend = word;
                m_pv = 1;
                m_bits.delete();
            end
        end
    endtask

    // one clock: apply inputs, predict, then record outputs #1 after the edge
    task automatic drive(input logic r, input logic v, input logic b);
        logic [EW-1:0] e;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: cycle %0d, limit %0d", cyc, MAXC);
            $fatal(1);
        end
        reset = r;
        in_valid = v;
        in = b;
        e = '0;
        if (r) model_reset();
        else if (v) model_bit(b, e);
        exp_ev[cyc] = e;
        @(posedge clk);
        #1;
        obs_ev[cyc] = {out_valid, sof, eof, flag, disc, err, out_data};
        cyc++;
    endtask

    task automatic send_bit(input logic b);
        if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        drive(1'b0, 1'b1, b);
    endtask

    task automatic send_raw(input logic [7:0] x);
        for (int i = 0; i < 8; i++) send_bit(x[i]);
    endtask

    task automatic send_flag();
        send_raw(8'h7E);
        enc_ones = 0;
    endtask

    task automatic send_stuffed(input logic [7:0] x);
        for (int i = 0; i < 8; i++) begin
            send_bit(x[i]);
            if (x[i]) begin
                enc_ones++;
                if (enc_ones == N) begin
                    send_bit(1'b0);
                    enc_ones = 0;
                end
            end else begin
                enc_ones = 0;
            end
        end
    endtask

    function automatic int count_bit(input int c0, input int c1, input int pos);
        int n = 0;
        for (int c = c0; c < c1; c++) if (obs_ev[c][pos]) n++;
        return n;
    endfunction

    function automatic int nth_valid(input int c0, input int c1, input int k);
        int n = 0;
        for (int c = c0; c < c1; c++) begin
            if (obs_ev[c][P_VAL]) begin
                if (n == k) return c;
                n++;
            end
        end
        return -1;
    endfunction

    task automatic test_reset();
        int c0;
        reset = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, (i == 0 || i == 7) ? 1'b0 : 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        for (int c = c0; c < cyc; c++) begin
            n_checks++;
            if (obs_ev[c] !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: cycle %0d got %h required 0", c, obs_ev[c]);
            end
        end
    endtask

    task automatic test_single_word();
        int c0, last, c;
        drive(1'b1, 1'b0, 1'b0);
        c0 = cyc;
        send_flag();
        send_stuffed(8'hA5);
        send_flag();
        last = cyc - 1;
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1);
        for (int k = c0; k < cyc; k++) begin
            n_checks++;
            if (obs_ev[k] !== exp_ev[k]) begin
                n_fail++;
                $display("FAIL single_model: cycle %0d got %h required %h", k, obs_ev[k], exp_ev[k]);
            end
        end
        n_checks++;
        if (count_bit(c0, cyc, P_FLAG) !== 2) begin
            n_fail++;
            $display("FAIL single_flags: got %0d required 2", count_bit(c0, cyc, P_FLAG));
        end
        c = nth_valid(c0, cyc, 0);
        n_checks++;
        if (c !== last || obs_ev[c][W-1:0] !== 8'hA5 || !obs_ev[c][P_SOF] || !obs_ev[c][P_EOF]) begin
            n_fail++;
            $display("FAIL single_word: cycle %0d required %0d, data %h required a5", c, last,
                     (c >= 0) ? obs_ev[c][W-1:0] : '0);
        end
    endtask

    task automatic test_stuffing();
        int c0, c;
        drive(1'b1, 1'b0, 1'b0);
        c0 = cyc;
        send_flag();
        send_stuffed(8'hFF);
        send_flag();
        drive(1'b0, 1'b0, 1'b0);
        for (int k = c0; k < cyc; k++) begin
            n_checks++;
            if (obs_ev[k] !== exp_ev[k]) begin
                n_fail++;
                $display("FAIL stuff_model: cycle %0d got %h required %h", k, obs_ev[k], exp_ev[k]);
            end
        end
        n_checks++;
        if (count_bit(c0, cyc, P_DISC) !== 1) begin
            n_fail++;
            $display("FAIL stuff_disc: got %0d required 1", count_bit(c0, cyc, P_DISC));
        end
        c = nth_valid(c0, cyc, 0);
        n_checks++;
        if (c < 0 || obs_ev[c][W-1:0] !== 8'hFF || !obs_ev[c][P_SOF] || !obs_ev[c][P_EOF]) begin
            n_fail++;
            $display("FAIL stuff_word: cycle %0d, required ff with sof and eof", c);
        end
    endtask

    task automatic test_two_words();
        int c0, last, ca, cb;
        drive(1'b1, 1'b0, 1'b0);
        c0 = cyc;
        send_flag();
        send_stuffed(8'h01);
        send_stuffed(8'h80);
        send_flag();
        last = cyc - 1;
        drive(1'b0, 1'b0, 1'b0);
        for (int k = c0; k < cyc; k++) begin
            n_checks++;
            if (obs_ev[k] !== exp_ev[k]) begin
                n_fail++;
                $display("FAIL two_model: cycle %0d got %h required %h", k, obs_ev[k], exp_ev[k]);
            end
        end
        ca = nth_valid(c0, cyc, 0);
        cb = nth_valid(c0, cyc, 1);
        n_checks++;
        if (ca < 0 || obs_ev[ca][W-1:0] !== 8'h01 || !obs_ev[ca][P_SOF] || obs_ev[ca][P_EOF]) begin
            n_fail++;
            $display("FAIL two_first: cycle %0d, required 01 sof=1 eof=0", ca);
        end
        n_checks++;
        if (cb !== last || obs_ev[cb][W-1:0] !== 8'h80 || obs_ev[cb][P_SOF] || !obs_ev[cb][P_EOF]) begin
            n_fail++;
            $display("FAIL two_second: cycle %0d required %0d, required 80 sof=0 eof=1", cb, last);
        end
    endtask

    task automatic test_abort();
        int c0, c_ab, c_rs;
        drive(1'b1, 1'b0, 1'b0);
        c0 = cyc;
        send_flag();
        send_stuffed(8'h12);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        c_ab = cyc;
        send_raw(8'hA5);
        send_raw(8'h3C);
        c_rs = cyc;
        send_flag();
        send_stuffed(8'h55);
        send_flag();
        drive(1'b0, 1'b0, 1'b0);
        for (int k = c0; k < cyc; k++) begin
            n_checks++;
            if (obs_ev[k] !== exp_ev[k]) begin
                n_fail++;
                $display("FAIL abort_model: cycle %0d got %h required %h", k, obs_ev[k], exp_ev[k]);
            end
        end
        n_checks++;
        if (count_bit(c0, c_rs, P_ERR) !== 1) begin
            n_fail++;
            $display("FAIL abort_err: got %0d required 1", count_bit(c0, c_rs, P_ERR));
        end
        n_checks++;
        if (count_bit(c0, c_rs, P_VAL) !== 0 || count_bit(c_ab, c_rs + 7, P_FLAG) !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: out_valid %0d required 0", count_bit(c0, c_rs, P_VAL));
        end
        n_checks++;
        if (count_bit(c_rs, cyc, P_EOF) !== 1) begin
            n_fail++;
            $display("FAIL abort_resync: eof %0d required 1", count_bit(c_rs, cyc, P_EOF));
        end
    endtask

    task automatic test_misalign();
        int c0, c_b2b;
        drive(1'b1, 1'b0, 1'b0);
        c0 = cyc;
        send_flag();
        send_stuffed(8'h12);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_flag();
        c_b2b = cyc;
        send_flag();
        send_flag();
        send_flag();
        drive(1'b0, 1'b0, 1'b0);
        for (int k = c0; k < cyc; k++) begin
            n_checks++;
            if (obs_ev[k] !== exp_ev[k]) begin
                n_fail++;
                $display("FAIL misalign_model: cycle %0d got %h required %h", k, obs_ev[k], exp_ev[k]);
            end
        end
        n_checks++;
        if (count_bit(c0, c_b2b, P_ERR) !== 1 || count_bit(c0, c_b2b, P_EOF) !== 0) begin
            n_fail++;
            $display("FAIL misalign_err: err %0d required 1", count_bit(c0, c_b2b, P_ERR));
        end
        n_checks++;
        if (count_bit(c_b2b, cyc, P_FLAG) !== 3 || count_bit(c_b2b, cyc, P_ERR) !== 0) begin
            n_fail++;
            $display("FAIL b2b_flags: flags %0d required 3, err %0d required 0",
                     count_bit(c_b2b, cyc, P_FLAG), count_bit(c_b2b, cyc, P_ERR));
        end
    endtask

    task automatic test_gapped_and_reset();
        int c0, c_rst, c_new, c;
        drive(1'b1, 1'b0, 1'b0);
        c0 = cyc;
        gap_mode = 1;
        send_flag();
        send_stuffed(8'hA5);
        send_flag();
        gap_mode = 0;
        drive(1'b0, 1'b0, 1'b0);
        c = nth_valid(c0, cyc, 0);
        n_checks++;
        if (c < 0 || obs_ev[c][W-1:0] !== 8'hA5 || !obs_ev[c][P_SOF] || !obs_ev[c][P_EOF]
            || count_bit(c0, cyc, P_FLAG) !== 2) begin
            n_fail++;
            $display("FAIL gapped_word: cycle %0d, flags %0d required 2", c, count_bit(c0, cyc, P_FLAG));
        end
        send_flag();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        c_rst = cyc;
        drive(1'b1, 1'b1, 1'b1);
        send_stuffed(8'hC3);
        send_stuffed(8'h0F);
        c_new = cyc;
        send_flag();
        send_stuffed(8'h66);
        send_flag();
        drive(1'b0, 1'b0, 1'b0);
        for (int k = c0; k < cyc; k++) begin
            n_checks++;
            if (obs_ev[k] !== exp_ev[k]) begin
                n_fail++;
                $display("FAIL gapped_model: cycle %0d got %h required %h", k, obs_ev[k], exp_ev[k]);
            end
        end
        for (int k = c_rst; k < c_new; k++) begin
            n_checks++;
            if (obs_ev[k] !== '0) begin
                n_fail++;
                $display("FAIL reset_midframe: cycle %0d got %h required 0", k, obs_ev[k]);
            end
        end
    endtask

    task automatic test_random();
        int c0, nbytes;
        drive(1'b1, 1'b0, 1'b0);
        c0 = cyc;
        for (int it = 0; it < 60; it++) begin
            gap_mode = $urandom_range(0, 2);
            send_flag();
            nbytes = $urandom_range(1, 4);
            for (int b = 0; b < nbytes; b++) begin
                if ($urandom_range(0, 3) == 0) send_stuffed(8'hFF);
                else send_stuffed(8'($urandom_range(0, 255)));
            end
            case ($urandom_range(0, 7))
                0: for (int i = 0; i < 7 + $urandom_range(0, 3); i++) send_bit(1'b1);
                1: for (int i = 0; i < $urandom_range(1, 7); i++) send_bit(1'($urandom_range(0, 1)));
                2: drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: ;
            endcase
            send_flag();
            if ($urandom_range(0, 2) == 0) send_flag();
        end
        gap_mode = 0;
        drive(1'b0, 1'b0, 1'b0);
        for (int k = c0; k < cyc; k++) begin
            n_checks++;
            if (obs_ev[k] !== exp_ev[k]) begin
                n_fail++;
                $display("FAIL random_model: cycle %0d got %h required %h", k, obs_ev[k], exp_ev[k]);
            end
        end
        n_checks++;
        if (count_bit(c0, cyc, P_EOF) < 10) begin
            n_fail++;
            $display("FAIL random_frames: eof count %0d required at least 10", count_bit(c0, cyc, P_EOF));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_word();
        test_stuffing();
        test_two_words();
        test_abort();
        test_misalign();
        test_gapped_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
